load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage load/store unit. Sits directly upstream of the byte-addressed data memory and is the only block that drives it.
- Takes one load or store request from the pipeline and returns the result with a request/response handshake.
- Does byte-lane steering, sign/zero extension, and read-modify-write for SB/SH, because the data memory only supports full 4-byte writes.

Parameters:
MEM_SIZE, 131072, data memory size in bytes; used for address range checking.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_store  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data; low bytes used for SB/SH
resp_valid  output  1  one-cycle pulse when the request completes
resp_data  output  32  load result; 0 for stores and faults
resp_err  output  1  valid with resp_valid; illegal funct3 or out-of-range address
mem_addr  output  32  data memory byte address
mem_wdata  output  32  data memory write data; [7:0] goes to mem_addr, [31:24] to mem_addr+3
mem_wen  output  1  data memory write enable
mem_rdata  input  32  combinational memory read; [31:24] = byte at mem_addr, [7:0] = byte at mem_addr+3

Behaviour:
- Reset (async, rst_n low): state = IDLE; all request registers cleared; req_ready=1; resp_valid=0; resp_data=0; resp_err=0; mem_addr=0; mem_wen=0.
- mem_wen and req_ready are decoded from the state register only, so reset mid-operation drops mem_wen at once and no write occurs.
- Little-endian value of the 4 bytes read: le = {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]}.
- States:
  - IDLE: on req_valid && req_ready, latch store/funct3/addr/wdata and go to ACCESS.
  - Fault check at latch time: set fault if funct3 is not legal for the operation, or if addr > MEM_SIZE-4. Stores allow only 000/001/010.
  - ACCESS: mem_addr = addr_q.
    - Fault: mem_wen=0, go to DONE with err.
    - Load: capture extracted result, go to DONE.
    - SW: mem_wen=1, mem_wdata = wdata_q, go to DONE.
    - SB/SH: capture merged word, go to WRITE.
  - WRITE: mem_addr = addr_q, mem_wen=1, mem_wdata = merged word, go to DONE.
  - DONE: resp_valid=1 for exactly one cycle, then go to IDLE. Response is not back-pressured. resp_data/resp_err hold their values until the next response.
- Load extraction, all from le:
  - LB: sign-extend le[7:0].
  - LBU: zero-extend le[7:0].
  - LH: sign-extend le[15:0].
  - LHU: zero-extend le[15:0].
  - LW: le.
- Store merge: SB gives {le[31:8], wdata[7:0]}; SH gives {le[31:16], wdata[15:0]}. The merge is in little-endian byte order, which matches mem_wdata lane order directly.
- Latency from accept cycle N: load, SW and fault respond at N+2; SB/SH respond at N+3. Throughput is one request per 3 or 4 cycles.
- No alignment restriction: any address with addr+3 < MEM_SIZE is legal.
- mem_wen is never asserted for faulted requests or for loads.
- req_valid seen outside IDLE is ignored (req_ready=0). The requester must hold the request until it is accepted.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum lsu_state_t {IDLE, ACCESS, WRITE, DONE};
  - function le_swap(word) for byte reversal.
- Sub-module lsu_lane_align is combinational: inputs mem_rdata, funct3, wdata; outputs load_result, merged_word. It is unit-testable on its own.
- load_store_unit keeps the FSM, request registers, fault check and response registers.

Test Plan:
- Preload bytes 0x100..0x103 = 11,22,33,84. LW 0x100 accepted at N -> resp_valid at N+2, resp_data=0x84332211, resp_err=0, mem_wen never high.
- Same preload. LB 0x103 -> 0xFFFFFF84. LBU 0x103 -> 0x00000084. LH 0x102 -> 0xFFFF8433. LHU 0x100 -> 0x00002211.
- Same preload. SB 0x100 wdata=0xDEADBEAB -> mem_wen only at N+2, mem_addr=0x100, mem_wdata=0x843322AB; then LW 0x100 -> 0x843322AB.
- Same preload. SH 0x100 wdata=0x0000BEEF -> mem_wdata=0x8433BEEF, resp at N+3. SW 0x104 wdata=0xCAFEF00D -> mem_wen at N+1 only, resp at N+2.
- Faults, both with mem_wen never asserted:
  - LW 0x1FFFD (MEM_SIZE-3) -> resp_err=1, resp_data=0 at N+2.
  - Store with funct3=100 -> resp_err=1.
- Issue SB, assert rst_n=0 during WRITE -> mem_wen falls combinationally in the same cycle, req_ready=1, resp_valid=0, memory unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states and
// the byte-order helper used between memory lane order and little-endian.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    DONE
  } lsu_state_t;

  // Reverse the four bytes of a word.
  function automatic logic [31:0] le_swap(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: load extraction and SB/SH merge word.
// mem_rdata arrives with the byte at the access address in [31:24]; both
// outputs are little-endian, which is also the memory write lane order.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_result,
  output logic [31:0] merged_word
);

  logic        [31:0] le;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign le     = le_swap(mem_rdata);
  assign byte_s = le[7:0];
  assign half_s = le[15:0];

  // Select extension for loads and merged lanes for partial stores by width code.
  always_comb begin
    load_result = le;
    merged_word = wdata;
    case (funct3)
      F3_B: begin
        load_result = 32'(byte_s);
        merged_word = {le[31:8], wdata[7:0]};
      end
      F3_H: begin
        load_result = 32'(half_s);
        merged_word = {le[31:16], wdata[15:0]};
      end
      F3_BU:   load_result = {24'd0, le[7:0]};
      F3_HU:   load_result = {16'd0, le[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit. Accepts one request at a time, performs
// the access (with read-modify-write for SB/SH since memory only takes
// full-word writes) and returns a one-cycle response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 131072
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  input  logic [31:0] mem_rdata
);

  // Highest legal start address: all four bytes must lie inside memory.
  localparam logic [31:0] ADDR_MAX = 32'(MEM_SIZE - 4);

  lsu_state_t  state, state_next;

  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        fault_q;
  logic [31:0] merged_q;

  logic        accept;
  logic        fault_in;
  logic        is_sw;
  logic [31:0] load_result;
  logic [31:0] merged_word;

  function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!store) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  assign accept   = req_valid && req_ready;
  assign fault_in = !funct3_legal(req_store, req_funct3) || (req_addr > ADDR_MAX);
  assign is_sw    = store_q && (funct3_q == F3_W);

  lsu_lane_align u_lane_align (
    .mem_rdata  (mem_rdata),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .load_result(load_result),
    .merged_word(merged_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and memory/handshake outputs, all decoded from registers so
  // an asynchronous reset removes mem_wen immediately.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_next = ACCESS;
      end
      ACCESS: begin
        if (fault_q) begin
          state_next = DONE;
        end else if (is_sw) begin
          mem_wen    = 1'b1;
          state_next = DONE;
        end else if (store_q) begin
          state_next = WRITE;
        end else begin
          state_next = DONE;
        end
      end
      WRITE: begin
        mem_wen    = 1'b1;
        mem_wdata  = merged_q;
        state_next = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture and fault classification at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      fault_q  <= 1'b0;
    end else if (accept) begin
      store_q  <= req_store;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      fault_q  <= fault_in;
    end
  end

  // Response registers update only on the way into DONE so they hold
  // between responses; the merge word is captured for the WRITE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data <= 32'd0;
      resp_err  <= 1'b0;
      merged_q  <= 32'd0;
    end else begin
      case (state)
        ACCESS: begin
          if (fault_q) begin
            resp_data <= 32'd0;
            resp_err  <= 1'b1;
          end else if (!store_q) begin
            resp_data <= load_result;
            resp_err  <= 1'b0;
          end else if (is_sw) begin
            resp_data <= 32'd0;
            resp_err  <= 1'b0;
          end else begin
            merged_q  <= merged_word;
          end
        end
        WRITE: begin
          resp_data <= 32'd0;
          resp_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// Directed bench for load_store_unit with a small byte-memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  // 256-byte window of memory, indexed by the low address byte.
  logic [7:0] mem [0:255];
  logic       clr = 1'b0;
  logic       poke_en = 1'b0;
  logic [7:0] poke_a = 8'd0;
  logic [7:0] poke_d = 8'd0;

  load_store_unit #(.MEM_SIZE(131072)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_rdata = {mem[mem_addr[7:0]], mem[8'(mem_addr[7:0] + 8'd1)],
                 mem[8'(mem_addr[7:0] + 8'd2)], mem[8'(mem_addr[7:0] + 8'd3)]};
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (poke_en) begin
      mem[poke_a] <= poke_d;
    end else if (mem_wen) begin
      mem[mem_addr[7:0]]               <= mem_wdata[7:0];
      mem[8'(mem_addr[7:0] + 8'd1)]    <= mem_wdata[15:8];
      mem[8'(mem_addr[7:0] + 8'd2)]    <= mem_wdata[23:16];
      mem[8'(mem_addr[7:0] + 8'd3)]    <= mem_wdata[31:24];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  int          lat;
  logic [31:0] rdata;
  logic        rerr;
  logic [7:0]  wmask;
  logic [31:0] waddr;
  logic [31:0] wdat;

  // Issue one request; report latency (edges after accept), response and
  // the cycles (bit k = k edges after accept) on which mem_wen was high.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    int k;
    int g;
    lat = 0; rdata = '0; rerr = 1'b0; wmask = '0; waddr = '0; wdat = '0;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 1;
    while (lat == 0 && k < 8) begin
      if (mem_wen) begin
        wmask[k] = 1'b1;
        waddr    = mem_addr;
        wdat     = mem_wdata;
      end
      if (resp_valid) begin
        lat   = k;
        rdata = resp_data;
        rerr  = resp_err;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
  endtask

  initial begin
    // Reset and memory preload
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data",  resp_data,       32'd0);
    chk("rst_resp_err",   32'(resp_err),   32'd0);
    chk("rst_mem_addr",   mem_addr,        32'd0);
    chk("rst_mem_wen",    32'(mem_wen),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    poke(8'h00, 8'h11);
    poke(8'h01, 8'h22);
    poke(8'h02, 8'h33);
    poke(8'h03, 8'h84);

    // Word load
    run_req(1'b0, 3'b010, 32'h100, 32'h0);
    chk("lw_lat",  32'(lat),   32'd2);
    chk("lw_data", rdata,      32'h84332211);
    chk("lw_err",  32'(rerr),  32'd0);
    chk("lw_wen",  32'(wmask), 32'd0);
    @(posedge clk); #1;
    chk("lw_pulse_end", 32'(resp_valid), 32'd0);
    chk("lw_data_hold", resp_data,       32'h84332211);

    // Sub-word loads with sign and zero extension
    run_req(1'b0, 3'b000, 32'h103, 32'h0);
    chk("lb_data", rdata, 32'hFFFFFF84);
    run_req(1'b0, 3'b100, 32'h103, 32'h0);
    chk("lbu_data", rdata, 32'h00000084);
    run_req(1'b0, 3'b001, 32'h102, 32'h0);
    chk("lh_data", rdata, 32'hFFFF8433);
    chk("lh_lat",  32'(lat), 32'd2);
    run_req(1'b0, 3'b101, 32'h100, 32'h0);
    chk("lhu_data", rdata, 32'h00002211);

    // Store byte: read-modify-write
    run_req(1'b1, 3'b000, 32'h100, 32'hDEADBEAB);
    chk("sb_wen_cycle", 32'(wmask), 32'h04);
    chk("sb_wen_addr",  waddr,      32'h100);
    chk("sb_wdata",     wdat,       32'h843322AB);
    chk("sb_lat",       32'(lat),   32'd3);
    chk("sb_resp_data", rdata,      32'd0);
    run_req(1'b0, 3'b010, 32'h100, 32'h0);
    chk("sb_readback", rdata, 32'h843322AB);
    poke(8'h00, 8'h11);

    // Store half and store word
    run_req(1'b1, 3'b001, 32'h100, 32'h0000BEEF);
    chk("sh_wdata",     wdat,       32'h8433BEEF);
    chk("sh_lat",       32'(lat),   32'd3);
    chk("sh_wen_cycle", 32'(wmask), 32'h04);
    run_req(1'b1, 3'b010, 32'h104, 32'hCAFEF00D);
    chk("sw_wen_cycle", 32'(wmask), 32'h02);
    chk("sw_lat",       32'(lat),   32'd2);
    chk("sw_wen_addr",  waddr,      32'h104);
    chk("sw_wdata",     wdat,       32'hCAFEF00D);
    @(negedge clk);
    chk("sw_mem_byte0", 32'(mem[8'h04]), 32'h0D);
    chk("sw_mem_byte3", 32'(mem[8'h07]), 32'hCA);

    // Faults and address boundary
    run_req(1'b0, 3'b010, 32'h0001FFFD, 32'h0);
    chk("oor_err",  32'(rerr),  32'd1);
    chk("oor_data", rdata,      32'd0);
    chk("oor_lat",  32'(lat),   32'd2);
    chk("oor_wen",  32'(wmask), 32'd0);
    run_req(1'b0, 3'b010, 32'h0001FFFC, 32'h0);
    chk("edge_ok_err", 32'(rerr), 32'd0);
    run_req(1'b1, 3'b100, 32'h100, 32'h12345678);
    chk("st_f3_err",  32'(rerr),  32'd1);
    chk("st_f3_wen",  32'(wmask), 32'd0);
    chk("st_f3_data", rdata,      32'd0);
    run_req(1'b0, 3'b011, 32'h100, 32'h0);
    chk("ld_f3_err", 32'(rerr), 32'd1);

    // Reset while the SB write is on the memory port
    poke(8'h08, 8'h55);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h108; req_wdata = 32'h000000AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstw_wen_before", 32'(mem_wen), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_wen_after",    32'(mem_wen),    32'd0);
    chk("rstw_req_ready",    32'(req_ready),  32'd1);
    chk("rstw_resp_valid",   32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("rstw_mem_unchanged", 32'(mem[8'h08]), 32'h55);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(1'b0, 3'b010, 32'h108, 32'h0);
    chk("rstw_readback", rdata, 32'h00000055);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
